// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the instruction register/datapath flags and the multicycle control FSM.
// The master side drives the instruction fields and flags; the slave side (the FSM) drives the controls.
interface multicycle_control_fsm_if #(
   parameter int ALUCTRL_W = 3,
   parameter int STATE_W   = 4
);
   logic [6:0]           op;
   logic [2:0]           funct3;
   logic                 funct7;
   logic                 zero;
   logic                 lt;
   logic                 mem_ready;
   logic                 pcwrite;
   logic                 adrsrc;
   logic                 memwrite;
   logic                 irwrite;
   logic [1:0]           resultsrc;
   logic [1:0]           alusrca;
   logic [1:0]           alusrcb;
   logic [1:0]           immsrc;
   logic                 regwrite;
   logic [ALUCTRL_W-1:0] alucontrol;
   logic                 illegal;
   logic [STATE_W-1:0]   state;

   modport master (
      output op, funct3, funct7, zero, lt, mem_ready,
      input  pcwrite, adrsrc, memwrite, irwrite, resultsrc, alusrca, alusrcb,
             immsrc, regwrite, alucontrol, illegal, state
   );

   modport slave (
      input  op, funct3, funct7, zero, lt, mem_ready,
      output pcwrite, adrsrc, memwrite, irwrite, resultsrc, alusrca, alusrcb,
             immsrc, regwrite, alucontrol, illegal, state
   );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Moore control FSM for a shared-memory multicycle RV32I datapath (fetch/decode/execute/memory/writeback).
// Define BRANCH_EXT_EN to accept bne/blt/bge; otherwise every 1100011 instruction is treated as beq.
module multicycle_control_fsm #(
   parameter int ALUCTRL_W = 3,
   parameter int STATE_W   = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   multicycle_control_fsm_if.slave bus
);

   typedef enum logic [STATE_W-1:0] {
      FETCH    = STATE_W'(0),
      DECODE   = STATE_W'(1),
      MEMADR   = STATE_W'(2),
      MEMREAD  = STATE_W'(3),
      MEMWB    = STATE_W'(4),
      MEMWRITE = STATE_W'(5),
      EXECUTER = STATE_W'(6),
      ALUWB    = STATE_W'(7),
      EXECUTEI = STATE_W'(8),
      JAL      = STATE_W'(9),
      BEQ      = STATE_W'(10),
      TRAP     = STATE_W'(11)
   } state_t;

   typedef struct packed {
      logic       isfetch;
      logic       adrsrc;
      logic       memwrite;
      logic [1:0] resultsrc;
      logic [1:0] alusrca;
      logic [1:0] alusrcb;
      logic       regwrite;
      logic [1:0] aluop;
      logic       branch;
      logic       pcupdate;
      logic       illegal;
   } ctrl_t;

   state_t               state;
   state_t               nxt;
   ctrl_t                ctrl;
   logic                 branch_ok;
   logic                 take;
   logic [ALUCTRL_W-1:0] aluctl;

   function automatic ctrl_t decode_ctrl(state_t s);
      ctrl_t c;
      c = '0;
      case (s)
         FETCH:    begin c.isfetch = 1'b1; c.alusrcb = 2'b10; c.resultsrc = 2'b10; end
         DECODE:   begin c.alusrca = 2'b01; c.alusrcb = 2'b01; end
         MEMADR:   begin c.alusrca = 2'b10; c.alusrcb = 2'b01; end
         MEMREAD:  c.adrsrc = 1'b1;
         MEMWB:    begin c.resultsrc = 2'b01; c.regwrite = 1'b1; end
         MEMWRITE: begin c.adrsrc = 1'b1; c.memwrite = 1'b1; end
         EXECUTER: begin c.alusrca = 2'b10; c.aluop = 2'b10; end
         EXECUTEI: begin c.alusrca = 2'b10; c.alusrcb = 2'b01; c.aluop = 2'b10; end
         ALUWB:    c.regwrite = 1'b1;
         JAL:      begin c.alusrca = 2'b01; c.alusrcb = 2'b10; c.pcupdate = 1'b1; end
         BEQ:      begin c.alusrca = 2'b10; c.aluop = 2'b01; c.branch = 1'b1; end
         TRAP:     c.illegal = 1'b1;
         default:  c = '0;
      endcase
      return c;
   endfunction

`ifdef BRANCH_EXT_EN
   // Branch condition select; unsupported funct3 under the branch opcode is diverted to TRAP.
   always_comb begin
      branch_ok = 1'b1;
      take      = 1'b0;
      case (bus.funct3)
         3'b000:  take = bus.zero;
         3'b001:  take = ~bus.zero;
         3'b100:  take = bus.lt;
         3'b101:  take = ~bus.lt;
         default: branch_ok = 1'b0;
      endcase
   end
`else
   logic unused_lt;
   assign unused_lt = bus.lt;
   assign branch_ok = 1'b1;
   assign take      = bus.zero;
`endif

   always_comb begin
      nxt = FETCH;
      case (state)
         FETCH:   nxt = bus.mem_ready ? DECODE : FETCH;
         DECODE: begin
            case (bus.op)
               7'b0000011, 7'b0100011: nxt = MEMADR;
               7'b0110011:             nxt = EXECUTER;
               7'b0010011:             nxt = EXECUTEI;
               7'b1100011:             nxt = branch_ok ? BEQ : TRAP;
               7'b1101111:             nxt = JAL;
               default:                nxt = TRAP;
            endcase
         end
         MEMADR:   nxt = bus.op[5] ? MEMWRITE : MEMREAD;
         MEMREAD:  nxt = bus.mem_ready ? MEMWB : MEMREAD;
         MEMWRITE: nxt = bus.mem_ready ? FETCH : MEMWRITE;
         EXECUTER, EXECUTEI, JAL: nxt = ALUWB;
         default:  nxt = FETCH;
      endcase
   end

   // Control bits are registered alongside the state so they come straight out of flops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= FETCH;
         ctrl  <= decode_ctrl(FETCH);
      end else begin
         state <= nxt;
         ctrl  <= decode_ctrl(nxt);
      end
   end

   always_comb begin
      aluctl = ALUCTRL_W'(4'b0000);
      case (ctrl.aluop)
         2'b01: aluctl = ALUCTRL_W'(4'b0001);
         2'b10: begin
            case (bus.funct3)
               3'b000: aluctl = (bus.op[5] & bus.funct7) ? ALUCTRL_W'(4'b0001) : ALUCTRL_W'(4'b0000);
               3'b010: aluctl = ALUCTRL_W'(4'b0101);
               3'b110: aluctl = ALUCTRL_W'(4'b0011);
               3'b111: aluctl = ALUCTRL_W'(4'b0010);
               3'b100: if (ALUCTRL_W == 4) aluctl = ALUCTRL_W'(4'b0100);
               3'b001: if (ALUCTRL_W == 4) aluctl = ALUCTRL_W'(4'b0110);
               3'b101: if (ALUCTRL_W == 4) aluctl = bus.funct7 ? ALUCTRL_W'(4'b1000) : ALUCTRL_W'(4'b0111);
               default: aluctl = ALUCTRL_W'(4'b0000);
            endcase
         end
         default: aluctl = ALUCTRL_W'(4'b0000);
      endcase
   end

   // Every output is forced low while reset is held; FETCH strobes follow mem_ready directly.
   assign bus.state      = rst_n ? state : '0;
   assign bus.pcwrite    = rst_n & ((ctrl.isfetch & bus.mem_ready) | ctrl.pcupdate | (ctrl.branch & take));
   assign bus.irwrite    = rst_n & ctrl.isfetch & bus.mem_ready;
   assign bus.adrsrc     = rst_n & ctrl.adrsrc;
   assign bus.memwrite   = rst_n & ctrl.memwrite;
   assign bus.regwrite   = rst_n & ctrl.regwrite;
   assign bus.illegal    = rst_n & ctrl.illegal;
   assign bus.resultsrc  = rst_n ? ctrl.resultsrc : 2'b00;
   assign bus.alusrca    = rst_n ? ctrl.alusrca : 2'b00;
   assign bus.alusrcb    = rst_n ? ctrl.alusrcb : 2'b00;
   assign bus.alucontrol = rst_n ? aluctl : '0;
   assign bus.immsrc     = !rst_n              ? 2'b00 :
                           (bus.op == 7'b0100011) ? 2'b01 :
                           (bus.op == 7'b1100011) ? 2'b10 :
                           (bus.op == 7'b1101111) ? 2'b11 : 2'b00;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench for multicycle_control_fsm: a per-cycle reference of the control sequence is queued and
// compared at each negedge; a second instance with ALUCTRL_W=4 shares the same inputs.
module tb_multicycle_control_fsm;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BR  = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   typedef struct packed {
      logic [3:0] state;
      logic       pcwrite;
      logic       adrsrc;
      logic       memwrite;
      logic       irwrite;
      logic [1:0] resultsrc;
      logic [1:0] alusrca;
      logic [1:0] alusrcb;
      logic [1:0] immsrc;
      logic       regwrite;
      logic       illegal;
      logic [2:0] alucontrol;
      logic [3:0] alucontrol4;
   } obs_t;

   logic clk = 1'b0;
   logic rst_n;
   int   tests = 0;
   int   fails = 0;
   obs_t q[$];

   multicycle_control_fsm_if bus ();
   multicycle_control_fsm_if #(.ALUCTRL_W(4)) bus4 ();

   assign bus4.op        = bus.op;
   assign bus4.funct3    = bus.funct3;
   assign bus4.funct7    = bus.funct7;
   assign bus4.zero      = bus.zero;
   assign bus4.lt        = bus.lt;
   assign bus4.mem_ready = bus.mem_ready;

   multicycle_control_fsm dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   multicycle_control_fsm #(.ALUCTRL_W(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

   always #5 clk = ~clk;

   function automatic logic m_branch_ok(logic [2:0] f3);
`ifdef BRANCH_EXT_EN
      return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b100) || (f3 == 3'b101);
`else
      return 1'b1;
`endif
   endfunction

   function automatic logic m_take(logic [2:0] f3, logic zero, logic lt);
`ifdef BRANCH_EXT_EN
      case (f3)
         3'b000:  return zero;
         3'b001:  return ~zero;
         3'b100:  return lt;
         3'b101:  return ~lt;
         default: return 1'b0;
      endcase
`else
      return zero;
`endif
   endfunction

   function automatic logic [3:0] m_alu(logic [1:0] aluop, logic [6:0] op, logic [2:0] f3, logic f7, logic ext);
      if (aluop == 2'b01) return 4'b0001;
      if (aluop != 2'b10) return 4'b0000;
      case (f3)
         3'b000:  return (op[5] && f7) ? 4'b0001 : 4'b0000;
         3'b010:  return 4'b0101;
         3'b110:  return 4'b0011;
         3'b111:  return 4'b0010;
         3'b100:  return ext ? 4'b0100 : 4'b0000;
         3'b001:  return ext ? 4'b0110 : 4'b0000;
         3'b101:  return ext ? (f7 ? 4'b1000 : 4'b0111) : 4'b0000;
         default: return 4'b0000;
      endcase
   endfunction

   function automatic logic [3:0] m_next(logic [3:0] s, logic [6:0] op, logic [2:0] f3, logic mr);
      case (s)
         4'd0: return mr ? 4'd1 : 4'd0;
         4'd1: begin
            if (op == OP_LW || op == OP_SW) return 4'd2;
            if (op == OP_R)   return 4'd6;
            if (op == OP_I)   return 4'd8;
            if (op == OP_BR)  return m_branch_ok(f3) ? 4'd10 : 4'd11;
            if (op == OP_JAL) return 4'd9;
            return 4'd11;
         end
         4'd2: return op[5] ? 4'd5 : 4'd3;
         4'd3: return mr ? 4'd4 : 4'd3;
         4'd5: return mr ? 4'd0 : 4'd5;
         4'd6, 4'd8, 4'd9: return 4'd7;
         default: return 4'd0;
      endcase
   endfunction

   function automatic obs_t m_out(logic [3:0] s, logic [6:0] op, logic [2:0] f3, logic f7,
                                  logic zero, logic lt, logic mr);
      obs_t o;
      logic [1:0] aluop;
      o = '0;
      aluop = 2'b00;
      o.state = s;
      o.immsrc = (op == OP_SW) ? 2'b01 : (op == OP_BR) ? 2'b10 : (op == OP_JAL) ? 2'b11 : 2'b00;
      case (s)
         4'd0:  begin o.irwrite = mr; o.pcwrite = mr; o.alusrcb = 2'b10; o.resultsrc = 2'b10; end
         4'd1:  begin o.alusrca = 2'b01; o.alusrcb = 2'b01; end
         4'd2:  begin o.alusrca = 2'b10; o.alusrcb = 2'b01; end
         4'd3:  o.adrsrc = 1'b1;
         4'd4:  begin o.resultsrc = 2'b01; o.regwrite = 1'b1; end
         4'd5:  begin o.adrsrc = 1'b1; o.memwrite = 1'b1; end
         4'd6:  begin o.alusrca = 2'b10; aluop = 2'b10; end
         4'd7:  o.regwrite = 1'b1;
         4'd8:  begin o.alusrca = 2'b10; o.alusrcb = 2'b01; aluop = 2'b10; end
         4'd9:  begin o.alusrca = 2'b01; o.alusrcb = 2'b10; o.pcwrite = 1'b1; end
         4'd10: begin o.alusrca = 2'b10; aluop = 2'b01; o.pcwrite = m_take(f3, zero, lt); end
         4'd11: o.illegal = 1'b1;
         default: o = '0;
      endcase
      o.alucontrol  = 3'(m_alu(aluop, op, f3, f7, 1'b0));
      o.alucontrol4 = m_alu(aluop, op, f3, f7, 1'b1);
      return o;
   endfunction

   function automatic obs_t sample();
      obs_t o;
      o.state       = bus.state;
      o.pcwrite     = bus.pcwrite;
      o.adrsrc      = bus.adrsrc;
      o.memwrite    = bus.memwrite;
      o.irwrite     = bus.irwrite;
      o.resultsrc   = bus.resultsrc;
      o.alusrca     = bus.alusrca;
      o.alusrcb     = bus.alusrcb;
      o.immsrc      = bus.immsrc;
      o.regwrite    = bus.regwrite;
      o.illegal     = bus.illegal;
      o.alucontrol  = bus.alucontrol;
      o.alucontrol4 = bus4.alucontrol;
      return o;
   endfunction

   // Drives one instruction from FETCH back to FETCH; expects to be entered just after a posedge.
   task automatic run_instr(input string name, input logic [6:0] op, input logic [2:0] f3, input logic f7,
                            input logic zero, input logic lt, input int fstall, input int mstall,
                            input int exp_lat, input int exp_memw, input int exp_ill);
      logic [3:0] s;
      logic       mr;
      obs_t       e;
      obs_t       got;
      int         n;
      int         memw;
      int         ill;
      int         fs;
      int         ms;
      bit         left;
      bit         done;
      bus.op = op; bus.funct3 = f3; bus.funct7 = f7; bus.zero = zero; bus.lt = lt;
      s = 4'd0; n = 0; memw = 0; ill = 0; fs = fstall; ms = mstall; left = 0; done = 0;
      while (!done && n < 40) begin
         mr = 1'b1;
         if (s == 4'd0 && fs > 0) begin mr = 1'b0; fs--; end
         if ((s == 4'd3 || s == 4'd5) && ms > 0) begin mr = 1'b0; ms--; end
         bus.mem_ready = mr;
         q.push_back(m_out(s, op, f3, f7, zero, lt, mr));
         @(negedge clk);
         got = sample();
         e = q.pop_front();
         tests++;
         if (got !== e) begin
            fails++;
            $display("[TB] FAIL %s cycle %0d: got %h expected %h", name, n, got, e);
         end
         memw += int'(got.memwrite);
         ill  += int'(got.illegal);
         s = m_next(s, op, f3, mr);
         if (s != 4'd0) left = 1;
         n++;
         @(posedge clk); #1;
         if (left && s == 4'd0) done = 1;
      end
      if (!done) begin
         tests++; fails++;
         $display("[TB] FAIL %s timeout: got %0d cycles without FETCH return, expected return", name, n);
      end
      if (exp_lat >= 0) begin
         tests++;
         if (n !== exp_lat) begin
            fails++;
            $display("[TB] FAIL %s latency: got %0d expected %0d", name, n, exp_lat);
         end
      end
      if (exp_memw >= 0) begin
         tests++;
         if (memw !== exp_memw) begin
            fails++;
            $display("[TB] FAIL %s memwrite cycles: got %0d expected %0d", name, memw, exp_memw);
         end
      end
      if (exp_ill >= 0) begin
         tests++;
         if (ill !== exp_ill) begin
            fails++;
            $display("[TB] FAIL %s illegal cycles: got %0d expected %0d", name, ill, exp_ill);
         end
      end
   endtask

   task automatic test_reset();
      obs_t got;
      rst_n = 1'b0;
      bus.op = OP_LW; bus.funct3 = 3'b010; bus.funct7 = 1'b0; bus.zero = 1'b0; bus.lt = 1'b0;
      bus.mem_ready = 1'b1;
      #2;
      got = sample();
      tests++;
      if (got !== obs_t'(0)) begin
         fails++; $display("[TB] FAIL reset_hold: got %h expected 0", got);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      got = sample();
      tests += 4;
      if (got.state !== 4'd0)      begin fails++; $display("[TB] FAIL release_state: got %0d expected 0", got.state); end
      if (got.irwrite !== 1'b1)    begin fails++; $display("[TB] FAIL release_irwrite: got %b expected 1", got.irwrite); end
      if (got.alusrcb !== 2'b10)   begin fails++; $display("[TB] FAIL release_alusrcb: got %b expected 10", got.alusrcb); end
      if (got.resultsrc !== 2'b10) begin fails++; $display("[TB] FAIL release_resultsrc: got %b expected 10", got.resultsrc); end
      repeat (3) @(posedge clk);
      #1 bus.mem_ready = 1'b0;
      @(negedge clk);
      got = sample();
      tests++;
      if (got.state !== 4'd3) begin fails++; $display("[TB] FAIL reach_memread: got %0d expected 3", got.state); end
      #2 rst_n = 1'b0;
      #1 got = sample();
      tests++;
      if (got !== obs_t'(0)) begin
         fails++; $display("[TB] FAIL reset_mid_memread: got %h expected 0", got);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      bus.mem_ready = 1'b1;
      bus.op = OP_I; bus.funct3 = 3'b000;
      @(negedge clk);
      got = sample();
      tests++;
      if (got !== m_out(4'd0, OP_I, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1)) begin
         fails++; $display("[TB] FAIL restart_fetch: got %h expected %h", got,
                           m_out(4'd0, OP_I, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1));
      end
      repeat (4) @(posedge clk);
      #1 got = sample();
      tests++;
      if (got.state !== 4'd0) begin fails++; $display("[TB] FAIL restart_return: got %0d expected 0", got.state); end
   endtask

   task automatic test_load();
      run_instr("lw", OP_LW, 3'b010, 1'b0, 1'b0, 1'b0, 0, 0, 5, 0, 0);
      run_instr("lw_stalled", OP_LW, 3'b010, 1'b0, 1'b0, 1'b0, 1, 2, 8, 0, 0);
   endtask

   task automatic test_store();
      run_instr("sw", OP_SW, 3'b010, 1'b0, 1'b0, 1'b0, 0, 0, 4, 1, 0);
      run_instr("sw_stalled", OP_SW, 3'b010, 1'b0, 1'b0, 1'b0, 0, 2, 6, 3, 0);
   endtask

   task automatic test_alu();
      for (int i = 0; i < 16; i++) begin
         run_instr("rtype", OP_R, 3'(i >> 1), 1'(i), 1'b0, 1'b0, 0, 0, 4, 0, 0);
         run_instr("itype", OP_I, 3'(i >> 1), 1'(i), 1'b0, 1'b0, 0, 0, 4, 0, 0);
      end
   endtask

   task automatic test_jal();
      run_instr("jal", OP_JAL, 3'b000, 1'b0, 1'b0, 1'b0, 0, 0, 4, 0, 0);
   endtask

   task automatic test_branch();
      for (int i = 0; i < 32; i++) begin
         run_instr("branch", OP_BR, 3'(i >> 2), 1'b0, 1'(i >> 1), 1'(i), 0, 0, 3, 0, m_branch_ok(3'(i >> 2)) ? 0 : 1);
      end
   endtask

   task automatic test_illegal();
      run_instr("illegal_ff", 7'b1111111, 3'b000, 1'b0, 1'b0, 1'b0, 0, 0, 3, 0, 1);
      run_instr("illegal_00", 7'b0000000, 3'b000, 1'b0, 1'b0, 1'b0, 0, 0, 3, 0, 1);
      run_instr("illegal_lui", 7'b0110111, 3'b000, 1'b0, 1'b0, 1'b0, 1, 0, 4, 0, 1);
   endtask

   task automatic test_back_to_back();
      logic [6:0] ops [8];
      ops = '{OP_LW, OP_SW, OP_R, OP_I, OP_BR, OP_JAL, 7'b1111111, OP_LW};
      for (int i = 0; i < 24; i++) begin
         run_instr("b2b", ops[$urandom_range(0, 7)], 3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                   int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), -1, -1, -1);
      end
   endtask

   initial begin
      test_reset();
      test_load();
      test_store();
      test_alu();
      test_jal();
      test_branch();
      test_illegal();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Parametrised successor to the single-cycle RV32I control path: a Moore FSM sequencing a shared-memory multicycle datapath across FETCH/DECODE/EXECUTE/MEM/WRITEBACK states.
- Reuses the same decode partition (main decode, then ALU decode from aluop/funct3/funct7[5]/op[5]), but adds per-cycle sequencing, a memory-ready handshake, illegal-opcode detection and a wider ALU-control option.
- Sits between the instruction register and the multicycle datapath muxes and enables.

Parameters:
- ALUCTRL_W, 3, alucontrol width. Legal values: 3 or 4; 4 enables the extended ALU ops.
- STATE_W, 4, state register width. Must be ≥4.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- op  input  7  instruction[6:0], from the IR
- funct3  input  3  instruction[14:12]
- funct7  input  1  instruction[30]
- zero  input  1  ALU zero flag
- lt  input  1  ALU signed less-than flag; used only with BRANCH_EXT_EN
- mem_ready  input  1  memory completed the access this cycle
- pcwrite  output  1  PC register enable
- adrsrc  output  1  memory address select: 0=PC, 1=ALUOut
- memwrite  output  1  memory write strobe
- irwrite  output  1  IR and OldPC enable
- resultsrc  output  2  result mux select: 00 ALUOut, 01 Data, 10 ALUResult
- alusrca  output  2  ALU A select: 00 PC, 01 OldPC, 10 rs1
- alusrcb  output  2  ALU B select: 00 rs2, 01 imm, 10 const 4
- immsrc  output  2  immediate type: I 00, S 01, B 10, J 11
- regwrite  output  1  register file write enable
- alucontrol  output  ALUCTRL_W  ALU operation
- illegal  output  1  one-cycle pulse on an unsupported opcode
- state  output  STATE_W  current state, for debug

Behaviour:
- State encoding:
  - FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTER 6, ALUWB 7, EXECUTEI 8, JAL 9, BEQ 10, TRAP 11.
- Reset: rst_n low forces state=FETCH asynchronously. While rst_n is low, all outputs are 0 (gated by rst_n). Reset mid-instruction abandons it; there is no partial writeback.
- Transitions:
  - FETCH -> DECODE when mem_ready=1; otherwise hold FETCH.
  - DECODE by op:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXECUTER
    - 0010011 -> EXECUTEI
    - 1100011 -> BEQ
    - 1101111 -> JAL
    - any other op -> TRAP
  - MEMADR -> MEMREAD if op[5]=0, else MEMWRITE.
  - MEMREAD -> MEMWB when mem_ready=1; otherwise hold.
  - MEMWRITE -> FETCH when mem_ready=1; otherwise hold, with memwrite held high.
  - MEMWB, BEQ, TRAP -> FETCH.
  - EXECUTER, EXECUTEI, JAL -> ALUWB; ALUWB -> FETCH.
- Moore outputs. Any signal not listed for a state is 0.
  - FETCH: irwrite=mem_ready, alusrcb=10, resultsrc=10, pcupdate=mem_ready.
  - DECODE: alusrca=01, alusrcb=01.
  - MEMADR: alusrca=10, alusrcb=01.
  - MEMREAD: adrsrc=1.
  - MEMWB: resultsrc=01, regwrite=1.
  - MEMWRITE: adrsrc=1, memwrite=1.
  - EXECUTER: alusrca=10, aluop=10.
  - EXECUTEI: alusrca=10, alusrcb=01, aluop=10.
  - ALUWB: regwrite=1.
  - JAL: alusrca=01, alusrcb=10, pcupdate=1.
  - BEQ: alusrca=10, aluop=01, branch=1.
  - TRAP: illegal=1.
- pcwrite = pcupdate | (branch & take). take = zero unless BRANCH_EXT_EN.
- immsrc: combinational from op, independent of state.
  - sw -> 01; branch -> 10; jal -> 11; all others -> 00.
- ALU decode:
  - aluop 00 -> add.
  - aluop 01 -> sub.
  - aluop 10 by funct3:
    - 000: sub if (op[5] & funct7), else add
    - 010: slt
    - 110: or
    - 111: and
  - Codes: add 000, sub 001, and 010, or 011, slt 101. When ALUCTRL_W=4, these are zero-extended.
  - ALUCTRL_W=4 adds: 100 xor -> 0100; 001 sll -> 0110; 101 -> srl 0111 if funct7=0, sra 1000 if funct7=1.
  - ALUCTRL_W=3: unsupported funct3 under aluop 10 -> add. No trap.
- Latencies with mem_ready tied high:
  - lw 5 cycles; sw 4; R-type and I-type 4; jal 4; beq 3; illegal 3.
  - Each low cycle of mem_ready adds one cycle in FETCH/MEMREAD/MEMWRITE.
- Unused state codes (12-15) -> FETCH on the next edge, with all outputs 0.

Optional Feature:
- Macro: BRANCH_EXT_EN.
- Defined:
  - Opcode 1100011 accepts funct3 000 beq, 001 bne, 100 blt, 101 bge.
  - take = zero, ~zero, lt, ~lt respectively.
  - Other funct3 values under this opcode -> TRAP instead of BEQ.
- Undefined:
  - Any funct3 under 1100011 is treated as beq (take = zero). lt is ignored.

Test Plan:
- Reset: rst_n low mid-MEMREAD -> state=0 immediately and all outputs 0. After release, first cycle shows irwrite=1, alusrcb=10, resultsrc=10.
- lw (op=0000011), mem_ready=1 -> states 0,1,2,3,4; regwrite=1 only in state 4 with resultsrc=01; total 5 cycles.
- sw with mem_ready low for 2 cycles in MEMWRITE -> memwrite=1 for 3 consecutive cycles, adrsrc=1, immsrc=01, then FETCH.
- R-type sub (funct3=000, funct7=1) -> alucontrol=001 in EXECUTER. With ALUCTRL_W=4 and funct3=101, funct7=1 -> alucontrol=1000.
- beq: zero=1 -> pcwrite=1 in BEQ; zero=0 -> pcwrite=0. With BRANCH_EXT_EN, bne and zero=0 -> pcwrite=1.
- op=1111111 -> states 0,1,11; illegal=1 for exactly one cycle; regwrite/memwrite stay 0; back to FETCH.
